rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, shared ROM address width.
REQ-002 SHALL have parameter DATA_W, default 24, ROM word width.
REQ-003 SHALL have parameter ROM_LAT, default 2, ROM read latency in cycles, range 1..4.
REQ-004 SHALL have parameter NES_BASE, default 18'h20000, word offset of the NES image in the shared ROM.
REQ-005 SHALL have the port clk, input, 1 bit: the single clock. All logic SHALL be on its rising edge.
REQ-006 SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have the port gb_req_valid, input, 1 bit: GB read request.
REQ-008 SHALL have the port gb_req_addr, input, ADDR_W bits: GB word address.
REQ-009 SHALL have the port gb_req_ready, output, 1 bit: the GB request is accepted this cycle.
REQ-010 SHALL have the port gb_rsp_valid, output, 1 bit: GB read data valid pulse.
REQ-011 SHALL have the port gb_rsp_data, output, DATA_W bits: GB read data.
REQ-012 SHALL have the port nes_req_valid, input, 1 bit: NES read request.
REQ-013 SHALL have the port nes_req_addr, input, ADDR_W-1 bits: NES word address.
REQ-014 SHALL have the port nes_req_ready, output, 1 bit: the NES request is accepted this cycle.
REQ-015 SHALL have the port nes_rsp_valid, output, 1 bit: NES read data valid pulse.
REQ-016 SHALL have the port nes_rsp_data, output, DATA_W bits: NES read data.
REQ-017 SHALL have the port rom_addr, output, ADDR_W bits: address to the single-port ROM.
REQ-018 SHALL have the port rom_data, input, DATA_W bits: ROM output, valid ROM_LAT cycles after rom_addr.
REQ-019 SHALL have the port conflict_cnt, output, 16 bits: saturating count of cycles with both requests pending.

Function
REQ-020 SHALL accept at most one request per cycle; acceptance = req_valid && req_ready in the same cycle.
REQ-021 SHALL drive req_ready combinationally from req_valid and the priority pointer, with no dependence on the rsp path; ready SHALL be 0 whenever the matching valid is 0.
REQ-022 SHALL grant the sole requester when only one requester is valid.
REQ-023 SHALL, when both are valid, grant the requester not granted last, then update the pointer so the other requester has priority next.
REQ-024 SHALL leave the pointer unchanged in cycles with no grant.
REQ-025 SHALL drive rom_addr combinationally with gb_req_addr on a GB grant and with (NES_BASE + nes_req_addr) mod 2^ADDR_W on a NES grant. With no grant, rom_addr SHALL hold its last granted value.
REQ-026 SHALL carry a ROM_LAT-deep pipeline of {valid, id} tags, one tag per accepted request.
REQ-027 SHALL assert the owner's rsp_valid for exactly one cycle, ROM_LAT cycles after acceptance, and capture rom_data into that owner's rsp_data in the same cycle.
REQ-028 SHALL hold rsp_data until the next response to the same owner.
REQ-029 SHALL deliver responses in acceptance order; back-to-back grants SHALL give back-to-back responses with no bubble.
REQ-030 SHALL bound the wait of a continuously valid requester to 1 lost cycle.
REQ-031 SHALL increment conflict_cnt when both valids are 1, saturate at 16'hFFFF and never wrap.
REQ-032 SHALL ignore a requester that drops valid without being accepted; no tag is issued for it.

Reset
REQ-033 SHALL, when rst_n=0 at a clock edge, clear all tag valids, set the pointer to GB priority, and zero conflict_cnt, gb_rsp_valid, nes_rsp_valid, gb_rsp_data, nes_rsp_data and the rom_addr register.
REQ-034 SHALL hold req_ready at 0 while rst_n=0.
REQ-035 SHALL drop responses in flight when reset is asserted mid-operation; no rsp_valid pulse may appear for requests accepted before reset.

Structure
REQ-036 SHALL take the requester-id encoding (GB=0, NES=1) and the default ADDR_W, DATA_W and NES_BASE from a shared package rom_pkg.
REQ-037 SHALL place the tag delay line in one sub-module, rom_tag_pipe, parameterised by ROM_LAT.

Verification
REQ-038 SHALL cover GB only: valid with addr 0x00010 for 1 cycle -> ready=1 that cycle, rom_addr=0x00010, gb_rsp_valid pulse ROM_LAT=2 cycles later with the ROM word, nes_rsp_valid=0.
REQ-039 SHALL cover NES offset: nes addr 0x00005 -> rom_addr=0x20005; nes addr 0x1FFFF with NES_BASE=0x20000 -> rom_addr=0x3FFFF.
REQ-040 SHALL cover contention: both valid for 6 cycles right after reset -> grants GB,NES,GB,NES,GB,NES; responses alternate with no bubble; conflict_cnt=6.
REQ-041 SHALL cover saturation: both valid for 70000 cycles -> conflict_cnt=16'hFFFF and stays there.
REQ-042 SHALL cover reset mid-flight: accept a GB request, assert rst_n=0 on the next edge -> no gb_rsp_valid; all outputs 0.
REQ-043 SHALL cover the ROM_LAT=1 and ROM_LAT=4 builds with the contention scenario -> response delay equals ROM_LAT exactly.

Source files
------------

// File: rtl/rom_pkg.sv
// -----------------------------------------------------------------------------
// rom_pkg
// Shared definitions for the GB/NES ROM arbiter: requester-id encoding, the
// response tag carried through the ROM latency pipeline, and the default
// address/data geometry of the shared ROM.
// No ports (package).
// -----------------------------------------------------------------------------
package rom_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 24;
  localparam logic [DEF_ADDR_W-1:0] DEF_NES_BASE = 18'h20000;

  // Requester identity; also the meaning of the round-robin priority pointer.
  typedef enum logic {
    REQ_GB  = 1'b0,
    REQ_NES = 1'b1
  } req_id_e;

  // One tag per accepted request, travelling alongside the ROM read.
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rom_tag_t;

  localparam rom_tag_t TAG_IDLE = '{valid: 1'b0, id: REQ_GB};

endpackage : rom_pkg

// File: rtl/rom_tag_pipe.sv
// -----------------------------------------------------------------------------
// rom_tag_pipe
// ROM_LAT-deep delay line of {valid, id} tags. A tag entering on tag_i leaves
// on tag_o exactly ROM_LAT cycles later, i.e. in the cycle the ROM presents
// the word for that request.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset; clears every stage
//   tag_i  - tag of the request accepted this cycle (valid=0 when none)
//   tag_o  - tag whose ROM data is on the ROM bus this cycle
// -----------------------------------------------------------------------------
module rom_tag_pipe
  import rom_pkg::*;
#(
  parameter int ROM_LAT = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rom_tag_t tag_i,
  output rom_tag_t tag_o
);

  rom_tag_t stage_q [ROM_LAT];

  // NOTE: every stage is reset, not just the valid bits of the first one;
  // clearing the whole line is what kills responses already in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) stage_q[i] <= TAG_IDLE;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < ROM_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[ROM_LAT-1];

endmodule : rom_tag_pipe

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
// Shares one single-port, fixed-latency ROM between a GB and a NES reader.
// One request is accepted per cycle; with both pending the grant alternates.
// Responses return ROM_LAT cycles after acceptance, in acceptance order.
// Ports:
//   clk, rst_n                 - clock and synchronous active-low reset
//   gb_req_valid/addr/ready    - GB request handshake (word address)
//   gb_rsp_valid/data          - GB one-cycle response pulse and held data
//   nes_req_valid/addr/ready   - NES request handshake (offset into NES image)
//   nes_rsp_valid/data         - NES one-cycle response pulse and held data
//   rom_addr                   - ROM address (combinational on a grant)
//   rom_data                   - ROM word, valid ROM_LAT cycles after rom_addr
//   conflict_cnt               - saturating count of cycles with both pending
// -----------------------------------------------------------------------------
module rom_arbiter
  import rom_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ROM_LAT  = 2,
  parameter logic [ADDR_W-1:0] NES_BASE = ADDR_W'(DEF_NES_BASE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gb_req_valid,
  input  logic [ADDR_W-1:0] gb_req_addr,
  output logic              gb_req_ready,
  output logic              gb_rsp_valid,
  output logic [DATA_W-1:0] gb_rsp_data,
  input  logic              nes_req_valid,
  input  logic [ADDR_W-2:0] nes_req_addr,
  output logic              nes_req_ready,
  output logic              nes_rsp_valid,
  output logic [DATA_W-1:0] nes_rsp_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [15:0]       conflict_cnt
);

  req_id_e           prio_q, prio_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;
  logic [DATA_W-1:0] gb_data_q, nes_data_q;
  logic              gb_grant, nes_grant;
  logic              gb_fire, nes_fire;
  rom_tag_t          tag_in, tag_out;

  // Grant: sole requester wins; on contention the pointer picks. Nothing is
  // granted while reset is held so no tag can be issued then.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gb_grant  = 1'b0;
    nes_grant = 1'b0;
    if (rst_n) begin
      if (gb_req_valid && nes_req_valid) begin
        gb_grant  = (prio_q == REQ_GB);
        nes_grant = (prio_q == REQ_NES);
      end else begin
        gb_grant  = gb_req_valid;
        nes_grant = nes_req_valid;
      end
    end
  end

  assign gb_req_ready  = gb_grant;
  assign nes_req_ready = nes_grant;

  // Pointer always favours whoever was not granted last; idle cycles keep it.
  always_comb begin
    prio_d         = prio_q;
    rom_addr_d     = rom_addr_q;
    conflict_cnt_d = conflict_cnt_q;
    if (gb_grant) begin
      prio_d     = REQ_NES;
      rom_addr_d = gb_req_addr;
    end else if (nes_grant) begin
      prio_d     = REQ_GB;
      // Sum is ADDR_W wide, so the NES window wraps modulo the ROM size.
      rom_addr_d = NES_BASE + ADDR_W'(nes_req_addr);
    end
    if (gb_req_valid && nes_req_valid && conflict_cnt_q != 16'hFFFF) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  assign rom_addr     = rom_addr_d;
  assign conflict_cnt = conflict_cnt_q;

  assign tag_in = '{valid: gb_grant | nes_grant,
                    id:    nes_grant ? REQ_NES : REQ_GB};

  rom_tag_pipe #(
    .ROM_LAT (ROM_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // The tag leaving the pipe lines up with rom_data; the owner sees the word
  // directly this cycle and the register keeps it until its next response.
  assign gb_fire  = rst_n && tag_out.valid && (tag_out.id == REQ_GB);
  assign nes_fire = rst_n && tag_out.valid && (tag_out.id == REQ_NES);

  assign gb_rsp_valid  = gb_fire;
  assign nes_rsp_valid = nes_fire;
  assign gb_rsp_data   = gb_fire  ? rom_data : gb_data_q;
  assign nes_rsp_data  = nes_fire ? rom_data : nes_data_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q         <= REQ_GB;
      rom_addr_q     <= '0;
      conflict_cnt_q <= '0;
      gb_data_q      <= '0;
      nes_data_q     <= '0;
    end else begin
      prio_q         <= prio_d;
      rom_addr_q     <= rom_addr_d;
      conflict_cnt_q <= conflict_cnt_d;
      if (gb_fire)  gb_data_q  <= rom_data;
      if (nes_fire) nes_data_q <= rom_data;
    end
  end

endmodule : rom_arbiter

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
// Three copies of rom_arbiter (ROM_LAT = 2, 1, 4) share one stimulus stream.
// Each has its own ROM model; a single reference model predicts every output
// of every copy each cycle, and directed sections pin literal expectations.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;

  localparam int NDUT = 3;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  // ROM contents: distinct word per address.
  function automatic logic [23:0] rom_word(input logic [17:0] a);
    return {a[5:0], a} ^ 24'hA5C35A;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gb_req_valid = 1'b0;
  logic [17:0] gb_req_addr = '0;
  logic        nes_req_valid = 1'b0;
  logic [16:0] nes_req_addr = '0;

  logic [NDUT-1:0]        gb_ready_w, nes_ready_w, gb_rv_w, nes_rv_w;
  logic [NDUT-1:0][23:0]  gb_data_w, nes_data_w, rom_data_w;
  logic [NDUT-1:0][17:0]  rom_addr_w;
  logic [NDUT-1:0][15:0]  cnt_w;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;

    rom_arbiter #(
      .ROM_LAT (L)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .gb_req_valid  (gb_req_valid),
      .gb_req_addr   (gb_req_addr),
      .gb_req_ready  (gb_ready_w[g]),
      .gb_rsp_valid  (gb_rv_w[g]),
      .gb_rsp_data   (gb_data_w[g]),
      .nes_req_valid (nes_req_valid),
      .nes_req_addr  (nes_req_addr),
      .nes_req_ready (nes_ready_w[g]),
      .nes_rsp_valid (nes_rv_w[g]),
      .nes_rsp_data  (nes_data_w[g]),
      .rom_addr      (rom_addr_w[g]),
      .rom_data      (rom_data_w[g]),
      .conflict_cnt  (cnt_w[g])
    );

    // Fixed-latency ROM: the word for the address seen L edges ago.
    logic [17:0] hist [4];
    initial for (int i = 0; i < 4; i++) hist[i] = '0;
    always @(posedge clk) begin
      hist[0] <= rom_addr_w[g];
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    end
    assign rom_data_w[g] = rom_word(hist[L-1]);
  end

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: grant rule, held address, saturating counter, and a
  // scoreboard of expected responses keyed by the cycle they are due in.
  // ---------------------------------------------------------------------------
  typedef struct {
    int          due;
    bit          nes;
    logic [23:0] data;
  } exp_t;

  exp_t        sbq [NDUT][$];
  exp_t        ent;
  bit          armed = 1'b0;
  bit          nes_last;
  int          cyc = 0;
  int          m_cnt;
  logic [17:0] held_addr, m_addr, m_nes_addr;
  logic [23:0] held_gb [NDUT];
  logic [23:0] held_nes [NDUT];
  bit          m_gg, m_ng, due, e_gv, e_nv;
  logic [23:0] e_gd, e_nd;

  always @(negedge clk) begin
    if (armed) begin
      m_gg = rst_n && gb_req_valid && (!nes_req_valid || nes_last);
      m_ng = rst_n && nes_req_valid && (!gb_req_valid || !nes_last);
      m_nes_addr = 18'h20000 + {1'b0, nes_req_addr};
      m_addr = m_gg ? gb_req_addr : (m_ng ? m_nes_addr : held_addr);
      for (int k = 0; k < NDUT; k++) begin
        due = (sbq[k].size() != 0) && (sbq[k][0].due == cyc);
        if (due) ent = sbq[k].pop_front();
        e_gv = rst_n && due && !ent.nes;
        e_nv = rst_n && due && ent.nes;
        e_gd = e_gv ? ent.data : held_gb[k];
        e_nd = e_nv ? ent.data : held_nes[k];
        check("gb_req_ready",  k, 32'(gb_ready_w[k]),  32'(m_gg));
        check("nes_req_ready", k, 32'(nes_ready_w[k]), 32'(m_ng));
        check("rom_addr",      k, 32'(rom_addr_w[k]),  32'(m_addr));
        check("conflict_cnt",  k, 32'(cnt_w[k]),       32'(m_cnt));
        check("gb_rsp_valid",  k, 32'(gb_rv_w[k]),     32'(e_gv));
        check("nes_rsp_valid", k, 32'(nes_rv_w[k]),    32'(e_nv));
        check("gb_rsp_data",   k, 32'(gb_data_w[k]),   32'(e_gd));
        check("nes_rsp_data",  k, 32'(nes_data_w[k]),  32'(e_nd));
        if (e_gv) held_gb[k]  = ent.data;
        if (e_nv) held_nes[k] = ent.data;
      end
      if (rst_n) begin
        if (gb_req_valid && nes_req_valid && m_cnt < 65535) m_cnt++;
        if (m_gg || m_ng) begin
          for (int k = 0; k < NDUT; k++)
            sbq[k].push_back('{due: cyc + lat_of(k), nes: m_ng, data: rom_word(m_addr)});
          nes_last  = m_ng;
          held_addr = m_addr;
        end
      end
    end
    if (!rst_n) begin
      armed     = 1'b1;
      nes_last  = 1'b1;
      m_cnt     = 0;
      held_addr = '0;
      for (int k = 0; k < NDUT; k++) begin
        sbq[k].delete();
        held_gb[k]  = '0;
        held_nes[k] = '0;
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus and literal expectations
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit gv, input logic [17:0] ga,
                       input bit nv, input logic [16:0] na);
    gb_req_valid  = gv;
    gb_req_addr   = ga;
    nes_req_valid = nv;
    nes_req_addr  = na;
  endtask

  int first [NDUT];
  int gb_pulses [NDUT];
  int nes_pulses [NDUT];

  initial begin
    // Reset with both requesters valid: nothing may be accepted.
    rst_n = 1'b0;
    drive(1'b1, 18'h00777, 1'b1, 17'h00003);
    repeat (3) tick();
    @(negedge clk);
    check("rst_gb_ready",  0, 32'(gb_ready_w[0]),  32'd0);
    check("rst_nes_ready", 0, 32'(nes_ready_w[0]), 32'd0);
    check("rst_cnt",       0, 32'(cnt_w[0]),       32'd0);
    check("rst_rom_addr",  0, 32'(rom_addr_w[0]),  32'd0);
    tick();

    // GB only, one cycle.
    rst_n = 1'b1;
    drive(1'b1, 18'h00010, 1'b0, '0);
    @(negedge clk);
    check("gb_only_ready", 0, 32'(gb_ready_w[0]), 32'd1);
    check("gb_only_addr",  0, 32'(rom_addr_w[0]), 32'h00010);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    check("gb_only_early", 0, 32'(gb_rv_w[0]), 32'd0);
    tick();
    @(negedge clk);
    check("gb_only_rsp",   0, 32'(gb_rv_w[0]),   32'd1);
    check("gb_only_data",  0, 32'(gb_data_w[0]), 32'hE5C34A);
    check("gb_only_nes",   0, 32'(nes_rv_w[0]),  32'd0);
    tick();

    // NES address offset and wrap into the top of the ROM.
    drive(1'b0, '0, 1'b1, 17'h00005);
    @(negedge clk);
    check("nes_addr_5",    0, 32'(rom_addr_w[0]), 32'h20005);
    tick();
    drive(1'b0, '0, 1'b1, 17'h1FFFF);
    @(negedge clk);
    check("nes_addr_max",  0, 32'(rom_addr_w[0]), 32'h3FFFF);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    check("addr_hold",     0, 32'(rom_addr_w[0]), 32'h3FFFF);
    tick();

    // Contention right after reset: six alternating grants.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 18'h01234, 1'b1, 17'h00456);
    for (int k = 0; k < NDUT; k++) begin
      first[k] = -1;
      gb_pulses[k] = 0;
      nes_pulses[k] = 0;
    end
    for (int j = 0; j < 10; j++) begin
      if (j == 6) drive(1'b0, '0, 1'b0, '0);
      @(negedge clk);
      if (j < 6) begin
        check("cont_gb_ready",  j, 32'(gb_ready_w[0]),  32'((j % 2) == 0));
        check("cont_nes_ready", j, 32'(nes_ready_w[0]), 32'((j % 2) == 1));
      end
      if (j == 6) check("cont_cnt", 0, 32'(cnt_w[0]), 32'd6);
      for (int k = 0; k < NDUT; k++) begin
        if (gb_rv_w[k] && first[k] < 0) first[k] = j;
        if (gb_rv_w[k])  gb_pulses[k]++;
        if (nes_rv_w[k]) nes_pulses[k]++;
      end
      tick();
      gb_req_addr  = gb_req_addr + 18'd1;
      nes_req_addr = nes_req_addr + 17'd1;
    end
    for (int k = 0; k < NDUT; k++) begin
      check("cont_latency",   k, 32'(first[k]),      32'(lat_of(k)));
      check("cont_gb_pulse",  k, 32'(gb_pulses[k]),  32'd3);
      check("cont_nes_pulse", k, 32'(nes_pulses[k]), 32'd3);
    end

    // Reset one cycle after a GB acceptance: the response must vanish.
    drive(1'b1, 18'h00123, 1'b0, '0);
    @(negedge clk);
    check("mid_accept", 0, 32'(gb_ready_w[0]), 32'd1);
    tick();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) check("mid_no_rsp", k, 32'(gb_rv_w[k]), 32'd0);
    tick();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check("mid_rom_addr", k, 32'(rom_addr_w[k]), 32'd0);
      check("mid_cnt",      k, 32'(cnt_w[k]),      32'd0);
      check("mid_gb_data",  k, 32'(gb_data_w[k]),  32'd0);
      check("mid_nes_data", k, 32'(nes_data_w[k]), 32'd0);
      check("mid_nes_rsp",  k, 32'(nes_rv_w[k]),   32'd0);
    end
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) check("mid_quiet", k, 32'(gb_rv_w[k]), 32'd0);
      tick();
    end

    // Random traffic with occasional resets; the model checks every cycle.
    for (int j = 0; j < 3000; j++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 2) != 0, 18'($urandom),
            $urandom_range(0, 2) != 0, 17'($urandom));
      tick();
    end

    // Long contention: counter must saturate and stay saturated.
    rst_n = 1'b1;
    drive(1'b1, 18'h00042, 1'b1, 17'h00024);
    repeat (70000) tick();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) check("sat_cnt", k, 32'(cnt_w[k]), 32'hFFFF);
    tick();
    tick();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) check("sat_hold", k, 32'(cnt_w[k]), 32'hFFFF);
    drive(1'b0, '0, 1'b0, '0);
    tick();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule : tb_rom_arbiter
